// File: rtl/arb2way16.sv
// Round-robin packet arbiter: two valid/ready sources share one registered 16-bit channel.
// Optional build macro ARB_BURST_LIMIT_EN adds a MAX_BURST-beat preemption limit.
module arb2way16 #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req0_last,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              req1_last,
    output logic              req1_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    output logic              out_last,
    input  logic              out_ready,
    output logic [1:0]        grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    if (MAX_BURST < 1) begin : g_cfg_check
        $error("arb2way16: MAX_BURST must be at least 1");
    end

    state_t            state;
    state_t            state_nxt;
    state_t            other_st_c;
    logic              rr_last;
    logic              rr_last_nxt;
    logic              sel_c;
    logic              slot_free_c;
    logic              accept_c;
    logic              last_c;
    logic              own_valid_c;
    logic              other_valid_c;
    logic [DATA_W-1:0] word_c;

`ifdef ARB_BURST_LIMIT_EN
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] burst_nxt;
    logic [CNT_W-1:0] burst_inc_c;
`endif

    // Grant, handshake and the 2:1 word mux all follow the registered state.
    always_comb begin
        sel_c         = (state == GNT1);
        grant         = {state == GNT1, state == GNT0};
        slot_free_c   = !out_valid || out_ready;
        req0_ready    = slot_free_c && grant[0];
        req1_ready    = slot_free_c && grant[1];
        accept_c      = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        word_c        = sel_c ? req1_data : req0_data;
        last_c        = sel_c ? req1_last : req0_last;
        own_valid_c   = sel_c ? req1_valid : req0_valid;
        other_valid_c = sel_c ? req0_valid : req1_valid;
        other_st_c    = sel_c ? GNT0 : GNT1;
    end

    always_comb begin
        state_nxt   = state;
        rr_last_nxt = rr_last;
`ifdef ARB_BURST_LIMIT_EN
        burst_nxt   = burst_cnt;
        burst_inc_c = (burst_cnt >= CNT_W'(MAX_BURST)) ? burst_cnt
                                                       : CNT_W'(burst_cnt + CNT_W'(1));
`endif
        case (state)
            IDLE: begin
                if (req0_valid && req1_valid) state_nxt = rr_last ? GNT0 : GNT1;
                else if (req0_valid)          state_nxt = GNT0;
                else if (req1_valid)          state_nxt = GNT1;
            end
            GNT0, GNT1: begin
                if (accept_c) begin
                    if (last_c) begin
                        rr_last_nxt = sel_c;
                        if (other_valid_c)    state_nxt = other_st_c;
                        else if (own_valid_c) state_nxt = state;
                        else                  state_nxt = IDLE;
`ifdef ARB_BURST_LIMIT_EN
                        burst_nxt = '0;
                    end else if (burst_inc_c >= CNT_W'(MAX_BURST) && other_valid_c) begin
                        // Long packet yields mid-stream; it resumes at its next grant.
                        state_nxt   = other_st_c;
                        rr_last_nxt = sel_c;
                        burst_nxt   = '0;
                    end else begin
                        burst_nxt = burst_inc_c;
`endif
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr_last <= 1'b1;
`ifdef ARB_BURST_LIMIT_EN
            burst_cnt <= '0;
`endif
        end else begin
            state   <= state_nxt;
            rr_last <= rr_last_nxt;
`ifdef ARB_BURST_LIMIT_EN
            burst_cnt <= burst_nxt;
`endif
        end
    end

    // Output register: load on accept, drop valid once the sink drains it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
            out_last  <= 1'b0;
        end else if (accept_c) begin
            out_valid <= 1'b1;
            out_data  <= word_c;
            out_src   <= sel_c;
            out_last  <= last_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arb2way16.sv
// Directed bench for arb2way16: cycle table plus a burst-limit sequence when ARB_BURST_LIMIT_EN is set.
module tb_arb2way16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_last, req0_ready;
    logic        req1_valid, req1_last, req1_ready;
    logic [15:0] req0_data, req1_data, out_data;
    logic        out_valid, out_src, out_last, out_ready;
    logic [1:0]  grant;

    int checks = 0;
    int errors = 0;

    arb2way16 #(.DATA_W(16), .MAX_BURST(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
        .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_last(out_last),
        .out_ready(out_ready), .grant(grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n, v0;
        logic [15:0] d0;
        logic        l0, v1;
        logic [15:0] d1;
        logic        l1, ordy;
        logic [1:0]  g;
        logic        r0, r1, ov;
        logic [15:0] od;
        logic        osrc, olast;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic rst, input logic v0, input logic [15:0] d0, input logic l0,
                                input logic v1, input logic [15:0] d1, input logic l1, input logic ordy,
                                input logic [1:0] g, input logic r0, input logic r1, input logic ov,
                                input logic [15:0] od, input logic osrc, input logic olast);
        vec_t v;
        v.rst_n = rst; v.v0 = v0; v.d0 = d0; v.l0 = l0; v.v1 = v1; v.d1 = d1; v.l1 = l1;
        v.ordy = ordy; v.g = g; v.r0 = r0; v.r1 = r1; v.ov = ov; v.od = od;
        v.osrc = osrc; v.olast = olast;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [17:0] act, input logic [17:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic v0, input logic [15:0] d0, input logic l0,
                         input logic v1, input logic [15:0] d1, input logic l1, input logic ordy);
        rst_n = rst; req0_valid = v0; req0_data = d0; req0_last = l0;
        req1_valid = v1; req1_data = d1; req1_last = l1; out_ready = ordy;
    endtask

    initial begin
        // Row k: inputs driven before edge k; expected values are those visible before that edge.
        vecs[0]  = mk(0,1,16'hAAAA,1, 1,16'h5555,1, 1, 2'b00,0,0,0,16'h0000,0,0);
        vecs[1]  = mk(1,1,16'hAAAA,1, 1,16'h5555,1, 1, 2'b00,0,0,0,16'h0000,0,0);
        vecs[2]  = mk(1,1,16'hAAAA,1, 1,16'h5555,1, 1, 2'b01,1,0,0,16'h0000,0,0);
        vecs[3]  = mk(1,0,16'h0000,0, 1,16'h5555,1, 1, 2'b10,0,1,1,16'hAAAA,0,1);
        vecs[4]  = mk(1,0,16'h0000,0, 0,16'h0000,0, 1, 2'b10,0,1,1,16'h5555,1,1);
        vecs[5]  = mk(0,0,16'h0000,0, 0,16'h0000,0, 1, 2'b10,0,1,0,16'h5555,1,1);
        vecs[6]  = mk(1,1,16'h0001,0, 0,16'h0000,0, 1, 2'b00,0,0,0,16'h0000,0,0);
        vecs[7]  = mk(1,1,16'h0001,0, 1,16'hBEEF,1, 1, 2'b01,1,0,0,16'h0000,0,0);
        vecs[8]  = mk(1,1,16'h0002,0, 1,16'hBEEF,1, 1, 2'b01,1,0,1,16'h0001,0,0);
        vecs[9]  = mk(1,1,16'h0003,0, 1,16'hBEEF,1, 1, 2'b01,1,0,1,16'h0002,0,0);
        vecs[10] = mk(1,1,16'h0004,1, 1,16'hBEEF,1, 0, 2'b01,0,0,1,16'h0003,0,0);
        vecs[11] = mk(1,1,16'h0004,1, 1,16'hBEEF,1, 0, 2'b01,0,0,1,16'h0003,0,0);
        vecs[12] = mk(1,1,16'h0004,1, 1,16'hBEEF,1, 0, 2'b01,0,0,1,16'h0003,0,0);
        vecs[13] = mk(1,1,16'h0004,1, 1,16'hBEEF,1, 1, 2'b01,1,0,1,16'h0003,0,0);
        vecs[14] = mk(1,0,16'h0000,0, 1,16'hBEEF,1, 1, 2'b10,0,1,1,16'h0004,0,1);
        vecs[15] = mk(1,1,16'h1111,1, 1,16'hC001,0, 1, 2'b10,0,1,1,16'hBEEF,1,1);
        vecs[16] = mk(0,1,16'h1111,1, 1,16'hC002,0, 1, 2'b10,0,1,1,16'hC001,1,0);
        vecs[17] = mk(1,1,16'h1111,1, 1,16'hC002,1, 1, 2'b00,0,0,0,16'h0000,0,0);
        vecs[18] = mk(1,1,16'h1111,1, 1,16'hC002,1, 1, 2'b01,1,0,0,16'h0000,0,0);
        vecs[19] = mk(1,0,16'h0000,0, 1,16'hC002,1, 1, 2'b10,0,1,1,16'h1111,0,1);
        vecs[20] = mk(1,0,16'h0000,0, 0,16'h0000,0, 0, 2'b10,0,0,1,16'hC002,1,1);
        vecs[21] = mk(1,0,16'h0000,0, 0,16'h0000,0, 1, 2'b10,0,1,1,16'hC002,1,1);
        vecs[22] = mk(1,0,16'h0000,0, 0,16'h0000,0, 1, 2'b10,0,1,0,16'hC002,1,1);

        drive(0, 1,16'hAAAA,1, 1,16'h5555,1, 1);
        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            drive(vecs[k].rst_n, vecs[k].v0, vecs[k].d0, vecs[k].l0,
                  vecs[k].v1, vecs[k].d1, vecs[k].l1, vecs[k].ordy);
            #1;
            chk("grant", k, 18'(grant), 18'(vecs[k].g));
            chk("readys", k, 18'({req0_ready, req1_ready}), 18'({vecs[k].r0, vecs[k].r1}));
            chk("out_valid", k, 18'(out_valid), 18'(vecs[k].ov));
            chk("out_word", k, {out_data, out_src, out_last}, {vecs[k].od, vecs[k].osrc, vecs[k].olast});
        end

`ifdef ARB_BURST_LIMIT_EN
        begin
            int i0 = 0;
            int i1 = 0;
            int got = 0;
            logic t0, t1;
            logic [17:0] exp_w;
            @(negedge clk);
            drive(0, 0,16'h0,0, 0,16'h0,0, 1);
            for (int cyc = 0; cyc < 100 && got < 14; cyc++) begin
                @(negedge clk);
                drive(1, i0 < 12, 16'(i0 + 1), i0 == 11, i1 < 2, 16'(16'hA000 + i1), i1 == 1, 1);
                #1;
                if (out_valid) begin
                    if (got < 8)       exp_w = {16'(got + 1), 1'b0, 1'b0};
                    else if (got < 10) exp_w = {16'(16'hA000 + got - 8), 1'b1, got == 9};
                    else               exp_w = {16'(got - 1), 1'b0, got == 13};
                    chk("burst_beat", got, {out_data, out_src, out_last}, exp_w);
                    got++;
                end
                t0 = req0_valid && req0_ready;
                t1 = req1_valid && req1_ready;
                @(posedge clk);
                if (t0) i0++;
                if (t1) i1++;
            end
            chk("burst_count", got, 18'(got), 18'(14));
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
